// File: rtl/nbbpu_pkg.sv
// nbbpu_pkg: shared sequencer state encoding and default load opcode
package nbbpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH_I,
      S_DATA,
      S_LATCH_D,
      S_EXEC
   } state_t;

   localparam logic [3:0] OP_LOAD_DEF = 4'hB;

   function automatic logic is_load(input logic [15:0] instr, input logic [3:0] op);
      return instr[15:12] == op;
   endfunction

endpackage

// File: rtl/nbbpu_sequencer.sv
// nbbpu_sequencer: multi-cycle fetch/load/execute sequencer sharing one single-port RAM between CPU and program loader
module nbbpu_sequencer
   import nbbpu_pkg::*;
#(
   parameter logic [3:0] OP_LOAD = OP_LOAD_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_run,
   input  logic [15:0] i_cpu_pc,
   input  logic [15:0] i_cpu_address,
   input  logic [15:0] i_cpu_write_data,
   input  logic        i_cpu_write_enable,
   output logic        o_cpu_enable,
   output logic [15:0] o_instruction,
   output logic [15:0] o_read_data,
   output logic [15:0] o_mem_address,
   output logic [15:0] o_mem_write_data,
   output logic        o_mem_write_enable,
   input  logic [15:0] i_mem_read_data,
   input  logic        i_load_valid,
   input  logic [15:0] i_load_address,
   input  logic [15:0] i_load_data,
   output logic        o_load_ready,
   output logic        o_busy
);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_instruction;
   logic [15:0] r_read_data;

   // State register; reset aborts any instruction in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next state: loader wins over run in IDLE, run only sampled at instruction boundaries
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    w_next = (!i_load_valid && i_run) ? S_FETCH : S_IDLE;
         S_FETCH:   w_next = S_LATCH_I;
         S_LATCH_I: w_next = is_load(i_mem_read_data, OP_LOAD) ? S_DATA : S_EXEC;
         S_DATA:    w_next = S_LATCH_D;
         S_LATCH_D: w_next = S_EXEC;
         S_EXEC:    w_next = i_run ? S_FETCH : S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Outputs: RAM port steering per state; writes only from loader (IDLE) or CPU store (EXEC)
   always_comb begin
      o_cpu_enable       = 1'b0;
      o_mem_address      = '0;
      o_mem_write_data   = '0;
      o_mem_write_enable = 1'b0;
      o_load_ready       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_load_valid) begin
               o_mem_address      = i_load_address;
               o_mem_write_data   = i_load_data;
               o_mem_write_enable = 1'b1;
               o_load_ready       = 1'b1;
            end
         end
         S_FETCH, S_LATCH_I: o_mem_address = i_cpu_pc;
         S_DATA, S_LATCH_D:  o_mem_address = i_cpu_address;
         S_EXEC: begin
            o_cpu_enable       = 1'b1;
            o_mem_address      = i_cpu_address;
            o_mem_write_data   = i_cpu_write_data;
            o_mem_write_enable = i_cpu_write_enable;
         end
         default: ;
      endcase
   end

   assign o_busy = r_state != S_IDLE;

   // Capture instruction and load data the cycle after their address was presented
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instruction <= '0;
         r_read_data   <= '0;
      end else begin
         if (r_state == S_LATCH_I) r_instruction <= i_mem_read_data;
         if (r_state == S_LATCH_D) r_read_data   <= i_mem_read_data;
      end
   end

   assign o_instruction = r_instruction;
   assign o_read_data   = r_read_data;

endmodule

// File: tb/tb_nbbpu_sequencer.sv
// tb_nbbpu_sequencer: randomized self-checking bench with a transaction-level memory/CPU model
module tb_nbbpu_sequencer;
   import nbbpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic [15:0] pc = '0, caddr = '0, cwd = '0;
   logic        cwe = 1'b0;
   logic        cpu_en, mwe, lr, busy;
   logic [15:0] instr, rdata, maddr, mwd, mrd;
   logic        lv = 1'b0;
   logic [15:0] la = '0, ld = '0;

   logic [15:0] ram     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] touched [$];
   logic [15:0] exp_rd = '0;
   int          n_vec = 0, n_err = 0;

   nbbpu_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
      .i_cpu_pc(pc), .i_cpu_address(caddr), .i_cpu_write_data(cwd), .i_cpu_write_enable(cwe),
      .o_cpu_enable(cpu_en), .o_instruction(instr), .o_read_data(rdata),
      .o_mem_address(maddr), .o_mem_write_data(mwd), .o_mem_write_enable(mwe),
      .i_mem_read_data(mrd),
      .i_load_valid(lv), .i_load_address(la), .i_load_data(ld), .o_load_ready(lr),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, read data one cycle after the address
   always @(posedge clk) begin
      if (mwe) ram[maddr] <= mwd;
      mrd <= ram[maddr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic load_word(input logic [15:0] a, input logic [15:0] d);
      lv = 1'b1; la = a; ld = d;
      #1;
      chk("ld_ready", lr, 1);
      chk("ld_addr", maddr, a);
      chk("ld_we", mwe, 1);
      chk("ld_data", mwd, d);
      cyc();
      lv = 1'b0;
      ref_mem[a] = d;
      touched.push_back(a);
   endtask

   function automatic logic [15:0] rand_word(input bit ldop);
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      if (op >= OP_LOAD_DEF) op = op + 4'd1;
      return {ldop ? OP_LOAD_DEF : op, 12'($urandom)};
   endfunction

   // Runs one instruction; first=1 starts from IDLE, else the sequencer is already in FETCH
   task automatic do_instr(input logic [15:0] p, input logic [15:0] a, input logic [15:0] w,
                           input logic we, input bit keep, input bit first, input bit drop,
                           input bit pend, input logic [15:0] pa, input logic [15:0] pd);
      int c, pulses, lat;
      bit ld_op, wbad, rbad;
      logic [15:0] exp_i;
      exp_i  = ref_mem[p];
      ld_op  = exp_i[15:12] == OP_LOAD_DEF;
      pulses = 0; lat = 0; wbad = 0; rbad = 0;
      pc = p; caddr = a; cwd = w; cwe = we;
      c = first ? 0 : 1;
      if (first) run = 1'b1;
      else begin
         #1;
         chk("fetch_addr", maddr, p);
         if (pend) begin lv = 1'b1; la = pa; ld = pd; end
      end
      while (pulses == 0 && c < 12) begin
         cyc();
         c++;
         if (!busy) wbad = 1;
         if (c == 1) begin
            chk("fetch_addr", maddr, p);
            if (pend) begin lv = 1'b1; la = pa; ld = pd; end
         end
         if (c >= 2 && lr) rbad = 1;
         if (ld_op && c == 3) chk("data_addr", maddr, a);
         if (drop && c == (ld_op ? 4 : 2)) run = 1'b0;
         if (cpu_en) begin
            pulses++;
            lat = c;
            if (ld_op) exp_rd = ref_mem[a];
            chk("latency", lat, ld_op ? 5 : 3);
            chk("instr", instr, exp_i);
            chk("rdata", rdata, exp_rd);
            chk("exec_addr", maddr, a);
            chk("exec_we", mwe, we);
            if (we) chk("exec_wd", mwd, w);
            run = keep;
         end else if (mwe) wbad = 1;
      end
      chk("one_pulse", pulses, 1);
      if (we && pulses == 1) begin ref_mem[a] = w; touched.push_back(a); end
      cyc();
      chk("busy_after", busy, keep);
      chk("no_2nd_pulse", cpu_en, 0);
      chk("quiet_busy", wbad, 0);
      if (pend) begin
         chk("ld_held_off", rbad, 0);
         chk("pend_ready", lr, 1);
         chk("pend_addr", maddr, pa);
         cyc();
         lv = 1'b0;
         ref_mem[pa] = pd;
         touched.push_back(pa);
      end
      cwe = 1'b0;
   endtask

   initial begin
      logic [15:0] gp [3], ga [3], gw [3];
      logic        gwe [3];
      int          n;
      for (int i = 0; i < 65536; i++) ref_mem[i] = '0;

      repeat (3) cyc();
      chk("rst_busy", busy, 0);
      chk("rst_en", cpu_en, 0);
      chk("rst_we", mwe, 0);
      chk("rst_lr", lr, 0);
      chk("rst_addr", maddr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_rdata", rdata, 0);
      rst_n = 1'b1;
      cyc();

      load_word(16'h0000, 16'h1234);
      do_instr(16'h0000, 16'h0040, 16'h0, 1'b0, 0, 1, 0, 0, 0, 0);

      load_word(16'h0000, 16'hB005);
      load_word(16'h0040, 16'hBEEF);
      do_instr(16'h0000, 16'h0040, 16'h0, 1'b0, 0, 1, 0, 0, 0, 0);

      load_word(16'h0010, 16'h1000);
      do_instr(16'h0010, 16'h0020, 16'hCAFE, 1'b1, 0, 1, 0, 0, 0, 0);
      chk("ram_store", ram[16'h0020], 16'hCAFE);

      load_word(16'h0030, 16'hB000);
      load_word(16'h0050, 16'h5A5A);
      do_instr(16'h0030, 16'h0050, 16'h0, 1'b0, 0, 1, 1, 0, 0, 0);

      load_word(16'h0060, 16'h2222);
      run = 1'b1;
      load_word(16'h0003, 16'h00AA);
      chk("ld_first_idle", busy, 0);
      cyc();
      chk("fetch_after_ld", busy, 1);
      do_instr(16'h0060, 16'h0070, 16'h0, 1'b0, 0, 0, 0, 0, 0, 0);

      load_word(16'h0080, 16'h3333);
      do_instr(16'h0080, 16'h0090, 16'h7777, 1'b1, 0, 1, 0, 1, 16'h00A0, 16'h4444);

      load_word(16'h0100, 16'hB123);
      load_word(16'h0200, 16'h1111);
      pc = 16'h0100; caddr = 16'h0200; cwd = 16'hDEAD; cwe = 1'b1; run = 1'b1;
      repeat (3) cyc();
      chk("in_data", maddr, 16'h0200);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_en", cpu_en, 0);
      chk("ar_we", mwe, 0);
      chk("ar_addr", maddr, 0);
      chk("ar_lr", lr, 0);
      chk("ar_instr", instr, 0);
      chk("ar_rdata", rdata, 0);
      run = 1'b0; cwe = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      exp_rd = '0;
      cyc();
      chk("ar_ram", ram[16'h0200], 16'h1111);

      repeat (25) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            bit ldop;
            ldop   = $urandom_range(0, 1) == 1;
            gp[i]  = 16'($urandom);
            ga[i]  = 16'($urandom);
            gw[i]  = 16'($urandom);
            gwe[i] = $urandom_range(0, 1) == 1;
            load_word(gp[i], rand_word(ldop));
            if (ldop) load_word(ga[i], 16'($urandom));
         end
         for (int i = 0; i < n; i++) begin
            bit last, drp, pnd;
            last = i == n - 1;
            drp  = last && $urandom_range(0, 3) == 0;
            pnd  = last && $urandom_range(0, 3) == 0;
            do_instr(gp[i], ga[i], gw[i], gwe[i], !last, i == 0, drp, pnd,
                     16'($urandom), 16'($urandom));
         end
      end

      foreach (touched[i]) chk("ram_final", ram[touched[i]], ref_mem[touched[i]]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nbbpu_sequencer.md
NBBPU_SEQUENCER -- requirements
Module: nbbpu_sequencer

Interface
REQ-001 Parameter OP_LOAD, default 4'hB, opcode (instruction[15:12]) that reads data memory.
REQ-002 clock  in  1  single system clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 run  in  1  level; 1 = execute instructions, 0 = halt at next instruction boundary.
REQ-005 cpu_PC  in  16  program counter from CPU.
REQ-006 cpu_address  in  16  data address from CPU.
REQ-007 cpu_write_data  in  16  store data from CPU.
REQ-008 cpu_write_enable  in  1  store request from CPU controller.
REQ-009 cpu_enable  out  1  one-cycle pulse; CPU updates PC/registers only when high.
REQ-010 instruction  out  16  latched instruction presented to CPU.
REQ-011 read_data  out  16  latched load data presented to CPU.
REQ-012 mem_address  out  16  single-port RAM address.
REQ-013 mem_write_data  out  16  RAM write data.
REQ-014 mem_write_enable  out  1  RAM write strobe.
REQ-015 mem_read_data  in  16  RAM read data; valid one cycle after address.
REQ-016 load_valid / load_address / load_data  in  1/16/16  external program-loader write request.
REQ-017 load_ready  out  1  loader write accepted this cycle.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, FETCH, LATCH_I, DATA, LATCH_D, EXEC.
REQ-020 IDLE: load_valid=1 -> mem_address=load_address, mem_write_data=load_data, mem_write_enable=1, load_ready=1, stay IDLE.
REQ-021 IDLE: load_valid=0 and run=1 -> FETCH; loader has priority when both asserted.
REQ-022 FETCH: mem_address=cpu_PC, mem_write_enable=0 -> LATCH_I.
REQ-023 LATCH_I: instruction <= mem_read_data; next DATA if mem_read_data[15:12]==OP_LOAD, else EXEC.
REQ-024 DATA: mem_address=cpu_address, mem_write_enable=0 -> LATCH_D.
REQ-025 LATCH_D: read_data <= mem_read_data -> EXEC.
REQ-026 EXEC: cpu_enable=1, mem_address=cpu_address, mem_write_data=cpu_write_data, mem_write_enable=cpu_write_enable; next FETCH if run=1, else IDLE.
REQ-027 Latency: non-load instruction 3 cycles (FETCH->EXEC), load 5 cycles; exactly one cpu_enable pulse per instruction.
REQ-028 run is sampled only in IDLE and EXEC; deassertion mid-instruction completes the current instruction.
REQ-029 load_ready=0 and memory untouched by loader outside IDLE; request stays pending, not dropped.
REQ-030 mem_write_enable never asserted in FETCH, LATCH_I, DATA, LATCH_D.
REQ-031 Addresses pass through unmodified; PC wrap 16'hFFFF->16'h0000 is the CPU's concern, no special case here.
REQ-032 instruction and read_data hold value until next overwrite.

Reset
REQ-033 reset=0 forces IDLE immediately regardless of clock; instruction=16'h0000, read_data=16'h0000.
REQ-034 During and after reset: cpu_enable=0, mem_write_enable=0, load_ready=0, busy=0, mem_address=16'h0000.
REQ-035 Reset mid-instruction aborts it: no cpu_enable pulse, no memory write issued.

Structure
REQ-036 State encodings and OP_LOAD default reside in shared nbbpu package/include; no other constants shared.
REQ-037 Single FSM module, no sub-module; state register plus instruction/read_data registers only.

Verification
REQ-038 RAM[0]=16'h1234 (non-load), run=1 from IDLE -> instruction=16'h1234 after LATCH_I, cpu_enable pulse 3 cycles after leaving IDLE.
REQ-039 RAM[0]=16'hB005, cpu_address=16'h0040, RAM[0x40]=16'hBEEF -> read_data=16'hBEEF, cpu_enable on 5th cycle, no write.
REQ-040 Store: cpu_write_enable=1, cpu_address=16'h0020, cpu_write_data=16'hCAFE in EXEC -> RAM[0x20]=16'hCAFE, single-cycle strobe.
REQ-041 run and load_valid both high in IDLE with load_address=16'h0003, load_data=16'h00AA -> loader write first, FETCH next cycle after load_valid drops.
REQ-042 run dropped during LATCH_D -> instruction completes, one cpu_enable, then IDLE, busy=0.
REQ-043 reset asserted in DATA -> immediate IDLE, all outputs zero, no cpu_enable, RAM unchanged.
